// File: rtl/framebuffer_read_requester_pkg.sv
// Shared definitions for the framebuffer read path (requester and serializer).
// Latency: n/a (constants and constant-evaluable helpers only).
// Backpressure: n/a.
//
// Contents:
//   BURST_INCR        AXI INCR burst encoding
//   axi_size()        arsize for a given data bus width
//   pix_to_tag_shift() right shift that turns a pixel index into a word tag
package framebuffer_read_requester_pkg;

  localparam logic [1:0] BURST_INCR = 2'b01;

  // log2 of bytes per beat; the bus width is a power-of-two multiple of 8.
  function automatic logic [2:0] axi_size(input int stream_width);
    return 3'($clog2(stream_width / 8));
  endfunction

  // Pixels per memory word is a power of two, so the word tag of a pixel
  // is its index shifted right by log2(pixels per word).
  function automatic int pix_to_tag_shift(input int stream_width, input int pixel_width);
    return $clog2(stream_width / pixel_width);
  endfunction

endpackage

// File: rtl/framebuffer_read_requester_if.sv
// AXI-Stream style pixel address channel (tvalid/tready/tdest/tlast).
// Latency: none, plain wires.
// Backpressure: source holds tvalid/tdest/tlast until tready.
//
// Modports:
//   master  drives tvalid, tdest, tlast; receives tready
//   slave   receives tvalid, tdest, tlast; drives tready
interface framebuffer_read_requester_if #(
  parameter int ADDR_WIDTH = 32
) ();

  logic                  tvalid;
  logic                  tready;
  logic [ADDR_WIDTH-1:0] tdest;
  logic                  tlast;

  modport master (output tvalid, output tdest, output tlast, input tready);
  modport slave  (input tvalid, input tdest, input tlast, output tready);

endinterface

// File: rtl/framebuffer_addr_fifo.sv
// Synchronous first-word-fall-through FIFO for pixel address entries.
// Latency: a write in cycle N is visible on rd_vld/rd_dat in N+1.
// Backpressure: full/empty are registered; a write while full is taken only
//   together with a read in the same cycle.
//
// Ports:
//   aclk, reset      clock, synchronous active-high reset (empties the FIFO)
//   wr_vld, wr_dat   write request and data
//   full             registered full flag
//   rd_rdy           consumer accepts the head entry
//   rd_vld, rd_dat   head entry valid / data (registered empty flag)
module framebuffer_addr_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 32
) (
  input  logic             aclk,
  input  logic             reset,
  input  logic             wr_vld,
  input  logic [WIDTH-1:0] wr_dat,
  output logic             full,
  input  logic             rd_rdy,
  output logic             rd_vld,
  output logic [WIDTH-1:0] rd_dat
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [AW:0]      count_nxt;
  logic             empty;
  logic             do_wr;
  logic             do_rd;

  assign do_rd = rd_rdy && !empty;
  assign do_wr = wr_vld && (!full || do_rd);

  always_comb begin
    count_nxt = count;
    if (do_wr && !do_rd) begin
      count_nxt = count + CNT_ONE;
    end else if (!do_wr && do_rd) begin
      count_nxt = count - CNT_ONE;
    end
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      full  <= (count_nxt == CNT_FULL);
      empty <= (count_nxt == '0);
    end
  end

  // Storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge aclk) begin
    if (do_wr) mem[wr_ptr] <= wr_dat;
  end

  assign rd_vld = !empty;
  assign rd_dat = mem[rd_ptr];

endmodule

// File: rtl/framebuffer_read_requester.sv
// Coalesces a pixel address stream into AXI INCR read bursts on AR and
//   forwards every pixel address, in order, to the framebuffer serializer.
// Latency: pixel accepted in N shows on m_fetch_axis in N+1 (FIFO empty);
//   a burst closed in N drives arvalid in N+1.
// Backpressure: tready drops when the FIFO is full, or when the pixel needs
//   a burst close and the AR register is still occupied.
//
// Build option: define FRAMEBUFFER_READ_4K_SPLIT_EN to stop bursts at
//   4 KiB byte-address boundaries.
//
// Ports:
//   aclk, reset          clock, synchronous active-high reset
//   s_addr_axis          incoming pixel indices (slave)
//   m_fetch_axis         pixel indices to the serializer (master)
//   m_mem_axi_ar*        AXI read address channel to memory
module framebuffer_read_requester
  import framebuffer_read_requester_pkg::*;
#(
  parameter int STREAM_WIDTH = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int ID_WIDTH     = 8,
  parameter int PIXEL_WIDTH  = 16,
  parameter int MAX_BURST    = 16,
  parameter int FIFO_DEPTH   = 32
) (
  input  logic                  aclk,
  input  logic                  reset,
  framebuffer_read_requester_if.slave  s_addr_axis,
  framebuffer_read_requester_if.master m_fetch_axis,
  output logic [ID_WIDTH-1:0]   m_mem_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_mem_axi_araddr,
  output logic [7:0]            m_mem_axi_arlen,
  output logic [2:0]            m_mem_axi_arsize,
  output logic [1:0]            m_mem_axi_arburst,
  output logic                  m_mem_axi_arvalid,
  input  logic                  m_mem_axi_arready
);

  localparam int          PIX_SHIFT = pix_to_tag_shift(STREAM_WIDTH, PIXEL_WIDTH);
  localparam logic [2:0]  AR_SIZE   = axi_size(STREAM_WIDTH);
  localparam logic [8:0]  BEAT_MAX  = 9'(MAX_BURST);

  // Open burst accumulator. A sealed burst already saw its tlast but could
  // not be issued yet; it accepts no further pixels.
  logic                  acc_open,  acc_open_nxt;
  logic                  acc_sealed, acc_sealed_nxt;
  logic [ADDR_WIDTH-1:0] acc_start, acc_start_nxt;
  logic [ADDR_WIDTH-1:0] acc_last,  acc_last_nxt;
  logic [8:0]            acc_beats, acc_beats_nxt;

  logic                  ld_ar;
  logic [ADDR_WIDTH-1:0] ld_start;
  logic [8:0]            ld_beats;

  logic [ADDR_WIDTH-1:0] in_tag;
  logic [ADDR_WIDTH-1:0] tag_next;
  logic                  split_here;
  logic                  can_join;
  logic                  pix_break;
  logic                  needs_close;
  logic                  ar_free;
  logic                  in_fire;
  logic                  fifo_full;
  logic                  fifo_vld;
  logic [ADDR_WIDTH:0]   fifo_dat;

  assign in_tag   = s_addr_axis.tdest >> PIX_SHIFT;
  assign tag_next = acc_last + ADDR_WIDTH'(1);

`ifdef FRAMEBUFFER_READ_4K_SPLIT_EN
  logic [11:0] next_byte_lo;
  assign next_byte_lo = 12'(tag_next << AR_SIZE);
  assign split_here   = (next_byte_lo == 12'h000);
`else
  assign split_here   = 1'b0;
`endif

  assign can_join = acc_open && !acc_sealed &&
                    ((in_tag == acc_last) ||
                     ((in_tag == tag_next) && (acc_beats < BEAT_MAX) && !split_here));

  // The pixel forces the open burst out, or closes its own burst via tlast.
  assign pix_break   = acc_open && !can_join;
  assign needs_close = pix_break || s_addr_axis.tlast;

  assign ar_free = !m_mem_axi_arvalid || m_mem_axi_arready;

  assign s_addr_axis.tready = !reset && !fifo_full && (ar_free || !needs_close);
  assign in_fire            = s_addr_axis.tvalid && s_addr_axis.tready;

  always_comb begin
    acc_open_nxt   = acc_open;
    acc_sealed_nxt = acc_sealed;
    acc_start_nxt  = acc_start;
    acc_last_nxt   = acc_last;
    acc_beats_nxt  = acc_beats;
    ld_ar          = 1'b0;
    ld_start       = acc_start;
    ld_beats       = acc_beats;

    if (in_fire) begin
      if (pix_break) begin
        // Issue the current burst and restart with this pixel. The AR
        // register is taken, so a tlast here seals the new burst instead.
        ld_ar          = 1'b1;
        acc_open_nxt   = 1'b1;
        acc_sealed_nxt = s_addr_axis.tlast;
        acc_start_nxt  = in_tag;
        acc_last_nxt   = in_tag;
        acc_beats_nxt  = 9'd1;
      end else begin
        if (can_join) begin
          if (in_tag != acc_last) begin
            acc_last_nxt  = in_tag;
            acc_beats_nxt = acc_beats + 9'd1;
          end
        end else begin
          acc_open_nxt   = 1'b1;
          acc_sealed_nxt = 1'b0;
          acc_start_nxt  = in_tag;
          acc_last_nxt   = in_tag;
          acc_beats_nxt  = 9'd1;
        end
        if (s_addr_axis.tlast) begin
          ld_ar          = 1'b1;
          ld_start       = acc_start_nxt;
          ld_beats       = acc_beats_nxt;
          acc_open_nxt   = 1'b0;
          acc_sealed_nxt = 1'b0;
        end
      end
    end else if (acc_open && ar_free && (!s_addr_axis.tvalid || acc_sealed)) begin
      // Nothing more is coming for this burst right now: issue it so the
      // serializer never waits on beats that were never requested.
      ld_ar          = 1'b1;
      acc_open_nxt   = 1'b0;
      acc_sealed_nxt = 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      acc_open          <= 1'b0;
      acc_sealed        <= 1'b0;
      acc_start         <= '0;
      acc_last          <= '0;
      acc_beats         <= '0;
      m_mem_axi_arvalid <= 1'b0;
      m_mem_axi_araddr  <= '0;
      m_mem_axi_arlen   <= '0;
    end else begin
      acc_open   <= acc_open_nxt;
      acc_sealed <= acc_sealed_nxt;
      acc_start  <= acc_start_nxt;
      acc_last   <= acc_last_nxt;
      acc_beats  <= acc_beats_nxt;
      if (ld_ar) begin
        m_mem_axi_arvalid <= 1'b1;
        m_mem_axi_araddr  <= ld_start << AR_SIZE;
        m_mem_axi_arlen   <= 8'(ld_beats - 9'd1);
      end else if (m_mem_axi_arready) begin
        m_mem_axi_arvalid <= 1'b0;
      end
    end
  end

  assign m_mem_axi_arid    = '0;
  assign m_mem_axi_arsize  = AR_SIZE;
  assign m_mem_axi_arburst = BURST_INCR;

  framebuffer_addr_fifo #(
    .WIDTH (ADDR_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_addr_fifo (
    .aclk   (aclk),
    .reset  (reset),
    .wr_vld (in_fire),
    .wr_dat ({s_addr_axis.tdest, s_addr_axis.tlast}),
    .full   (fifo_full),
    .rd_rdy (m_fetch_axis.tready),
    .rd_vld (fifo_vld),
    .rd_dat (fifo_dat)
  );

  assign m_fetch_axis.tvalid = fifo_vld;
  assign m_fetch_axis.tdest  = fifo_dat[ADDR_WIDTH:1];
  assign m_fetch_axis.tlast  = fifo_vld && fifo_dat[0];

endmodule

// File: tb/tb_framebuffer_read_requester.sv
// Directed bench for framebuffer_read_requester with default parameters
// (two 16-bit pixels per 32-bit word, MAX_BURST 16, FIFO depth 32).
module tb_framebuffer_read_requester;

  logic        aclk = 1'b0;
  logic        reset;
  logic [7:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;

  framebuffer_read_requester_if #(.ADDR_WIDTH(32)) s_addr_if ();
  framebuffer_read_requester_if #(.ADDR_WIDTH(32)) m_fetch_if ();

  framebuffer_read_requester dut (
    .aclk              (aclk),
    .reset             (reset),
    .s_addr_axis       (s_addr_if),
    .m_fetch_axis      (m_fetch_if),
    .m_mem_axi_arid    (arid),
    .m_mem_axi_araddr  (araddr),
    .m_mem_axi_arlen   (arlen),
    .m_mem_axi_arsize  (arsize),
    .m_mem_axi_arburst (arburst),
    .m_mem_axi_arvalid (arvalid),
    .m_mem_axi_arready (arready)
  );

  always #5 aclk = ~aclk;

  int n_cmp = 0;
  int n_err = 0;
  int in_cnt = 0;

  logic [32:0] fetch_q[$];
  logic [32:0] exp_fetch_q[$];
  logic [31:0] ar_addr_q[$];
  logic [7:0]  ar_len_q[$];

  logic        ar_stalled = 1'b0;
  logic [31:0] held_addr;
  logic [7:0]  held_len;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Handshakes are sampled mid-cycle; they commit at the following posedge.
  always @(negedge aclk) begin
    if (!reset) begin
      if (m_fetch_if.tvalid && m_fetch_if.tready)
        fetch_q.push_back({m_fetch_if.tdest, m_fetch_if.tlast});
      if (arvalid && arready) begin
        ar_addr_q.push_back(araddr);
        ar_len_q.push_back(arlen);
      end
      if (s_addr_if.tvalid && s_addr_if.tready)
        in_cnt <= in_cnt + 1;
      if (ar_stalled) begin
        check_eq("ar_hold_vld", 64'(arvalid), 64'(1));
        check_eq("ar_hold_addr", 64'(araddr), 64'(held_addr));
        check_eq("ar_hold_len", 64'(arlen), 64'(held_len));
      end
    end
    ar_stalled <= !reset && arvalid && !arready;
    held_addr  <= araddr;
    held_len   <= arlen;
  end

  task automatic send_pix(input int pix, input bit tl);
    bit acc = 1'b0;
    s_addr_if.tvalid = 1'b1;
    s_addr_if.tdest  = 32'(pix);
    s_addr_if.tlast  = tl;
    exp_fetch_q.push_back({32'(pix), tl});
    for (int t = 0; t < 300; t++) begin
      @(negedge aclk);
      if (s_addr_if.tready) begin
        acc = 1'b1;
        break;
      end
    end
    check_eq("send_accept", 64'(acc), 64'(1));
    @(posedge aclk);
    #1;
  endtask

  task automatic stream(input int first, input int last, input bit tl_end);
    for (int p = first; p <= last; p++)
      send_pix(p, tl_end && (p == last));
    s_addr_if.tvalid = 1'b0;
    s_addr_if.tlast  = 1'b0;
  endtask

  task automatic wait_for(input int n_fetch, input int n_ar);
    int t = 0;
    while ((fetch_q.size() < n_fetch || ar_addr_q.size() < n_ar) && t < 2000) begin
      @(negedge aclk);
      t++;
    end
    repeat (8) @(negedge aclk);
    check_eq("fetch_count", 64'(fetch_q.size()), 64'(n_fetch));
    check_eq("ar_count", 64'(ar_addr_q.size()), 64'(n_ar));
  endtask

  task automatic check_fetch(input string tag);
    for (int i = 0; i < exp_fetch_q.size(); i++)
      if (i < fetch_q.size())
        check_eq(tag, 64'(fetch_q[i]), 64'(exp_fetch_q[i]));
  endtask

  task automatic check_ar(input int idx, input logic [31:0] addr, input logic [7:0] len);
    if (idx < ar_addr_q.size()) begin
      check_eq("ar_addr", 64'(ar_addr_q[idx]), 64'(addr));
      check_eq("ar_len", 64'(ar_len_q[idx]), 64'(len));
    end else begin
      check_eq("ar_present", 64'(ar_addr_q.size()), 64'(idx + 1));
    end
  endtask

  task automatic clear_q();
    @(posedge aclk);
    #1;
    fetch_q.delete();
    exp_fetch_q.delete();
    ar_addr_q.delete();
    ar_len_q.delete();
  endtask

  initial begin
    int base;
    int t;
    reset               = 1'b1;
    arready             = 1'b1;
    m_fetch_if.tready   = 1'b1;
    s_addr_if.tvalid    = 1'b0;
    s_addr_if.tdest     = '0;
    s_addr_if.tlast     = 1'b0;

    // Reset state
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check_eq("rst_tready", 64'(s_addr_if.tready), 64'(0));
    check_eq("rst_fetch_vld", 64'(m_fetch_if.tvalid), 64'(0));
    check_eq("rst_fetch_last", 64'(m_fetch_if.tlast), 64'(0));
    check_eq("rst_arvalid", 64'(arvalid), 64'(0));
    check_eq("rst_arid", 64'(arid), 64'(0));
    check_eq("rst_arsize", 64'(arsize), 64'(2));
    check_eq("rst_arburst", 64'(arburst), 64'(1));
    check_eq("rst_araddr", 64'(araddr), 64'(0));
    check_eq("rst_arlen", 64'(arlen), 64'(0));
    @(posedge aclk);
    #1;
    reset = 1'b0;
    @(negedge aclk);
    check_eq("idle_tready", 64'(s_addr_if.tready), 64'(1));
    clear_q();

    // 1: pixels 0..7, one burst of 4 beats
    stream(0, 7, 1'b1);
    wait_for(8, 1);
    check_fetch("s1_fetch");
    check_ar(0, 32'h0, 8'd3);
    clear_q();

    // 2: 0,1,2 then a jump to 100 with tlast
    send_pix(0, 1'b0);
    send_pix(1, 1'b0);
    send_pix(2, 1'b0);
    send_pix(100, 1'b1);
    s_addr_if.tvalid = 1'b0;
    s_addr_if.tlast  = 1'b0;
    wait_for(4, 2);
    check_fetch("s2_fetch");
    check_ar(0, 32'h0, 8'd1);
    check_ar(1, 32'hC8, 8'd0);
    clear_q();

    // 3: 40 pixels, split by MAX_BURST
    stream(0, 39, 1'b1);
    wait_for(40, 2);
    check_fetch("s3_fetch");
    check_ar(0, 32'h0, 8'd15);
    check_ar(1, 32'h40, 8'd3);
    clear_q();

    // 4: run across the 4 KiB boundary
    stream(2044, 2051, 1'b1);
`ifdef FRAMEBUFFER_READ_4K_SPLIT_EN
    wait_for(8, 2);
    check_ar(0, 32'hFF8, 8'd1);
    check_ar(1, 32'h1000, 8'd1);
`else
    wait_for(8, 1);
    check_ar(0, 32'hFF8, 8'd3);
`endif
    check_fetch("s4_fetch");
    clear_q();

    // 5: FIFO fills with the serializer stalled, then AR held off
    arready           = 1'b0;
    m_fetch_if.tready = 1'b0;
    base              = in_cnt;
    fork
      stream(0, 39, 1'b1);
      begin
        t = 0;
        while (in_cnt - base < 32 && t < 500) begin
          @(negedge aclk);
          t++;
        end
        @(posedge aclk);
        @(negedge aclk);
        check_eq("s5_tready_full", 64'(s_addr_if.tready), 64'(0));
        @(posedge aclk);
        #1;
        m_fetch_if.tready = 1'b1;
        t = 0;
        while (!arvalid && t < 200) begin
          @(negedge aclk);
          t++;
        end
        check_eq("s5_arvalid", 64'(arvalid), 64'(1));
        check_eq("s5_araddr", 64'(araddr), 64'(0));
        check_eq("s5_arlen", 64'(arlen), 64'(15));
        repeat (10) @(negedge aclk);
        check_eq("s5_tready_arbusy", 64'(s_addr_if.tready), 64'(0));
        check_eq("s5_arvalid_held", 64'(arvalid), 64'(1));
        @(posedge aclk);
        #1;
        arready = 1'b1;
      end
    join
    wait_for(40, 2);
    check_fetch("s5_fetch");
    check_ar(0, 32'h0, 8'd15);
    check_ar(1, 32'h40, 8'd3);
    clear_q();

    // 6: reset in the middle of a burst, then a fresh stream
    arready           = 1'b0;
    m_fetch_if.tready = 1'b0;
    stream(0, 5, 1'b0);
    reset = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    check_eq("s6_rst_arvalid", 64'(arvalid), 64'(0));
    check_eq("s6_rst_fetch_vld", 64'(m_fetch_if.tvalid), 64'(0));
    check_eq("s6_rst_tready", 64'(s_addr_if.tready), 64'(0));
    @(posedge aclk);
    #1;
    reset             = 1'b0;
    arready           = 1'b1;
    m_fetch_if.tready = 1'b1;
    clear_q();
    stream(64, 67, 1'b1);
    wait_for(4, 1);
    check_fetch("s6_fetch");
    check_ar(0, 32'h80, 8'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/framebuffer_read_requester.md
# framebuffer_read_requester

Upstream neighbour of the framebuffer serializer. It accepts a stream of pixel addresses, coalesces consecutive pixels into AXI INCR read bursts on the memory AR channel, and forwards every pixel address, in order, on the fetch stream the serializer consumes. The serializer then pairs those addresses with the returned R beats.

## Interface
Parameters:
- STREAM_WIDTH, 32: memory data width in bits.
- ADDR_WIDTH, 32: address width for tdest and araddr.
- ID_WIDTH, 8: width of arid.
- PIXEL_WIDTH, 16: pixel width in bits; STREAM_WIDTH/PIXEL_WIDTH is a power of two.
- MAX_BURST, 16: maximum beats per burst, 1..256.
- FIFO_DEPTH, 32: depth of the pixel address FIFO, power of two.

Ports:
- aclk  in  1  clock; one clock domain.
- reset  in  1  synchronous, active-high reset.
- s_addr_axis_tvalid  in  1  pixel address valid.
- s_addr_axis_tready  out  1  pixel address accepted.
- s_addr_axis_tdest  in  ADDR_WIDTH  pixel index.
- s_addr_axis_tlast  in  1  last pixel of a transfer.
- m_fetch_axis_tvalid  out  1  to serializer.
- m_fetch_axis_tready  in  1  from serializer.
- m_fetch_axis_tdest  out  ADDR_WIDTH  pixel index, unchanged.
- m_fetch_axis_tlast  out  1  unchanged tlast.
- m_mem_axi_arid  out  ID_WIDTH  constant 0.
- m_mem_axi_araddr  out  ADDR_WIDTH  burst byte address.
- m_mem_axi_arlen  out  8  beats minus 1.
- m_mem_axi_arsize  out  3  log2(STREAM_WIDTH/8).
- m_mem_axi_arburst  out  2  constant 2'b01 (INCR).
- m_mem_axi_arvalid  out  1  address valid.
- m_mem_axi_arready  in  1  address accepted.

## Operation
Address mapping:
- tag = tdest >> log2(STREAM_WIDTH/PIXEL_WIDTH).
- araddr = start tag << log2(STREAM_WIDTH/8), truncated to ADDR_WIDTH.

Accumulator holds one open burst: open flag, startTag, lastTag, beats (9 bits).

Each accepted pixel is always written to the FIFO as {tdest, tlast}, and:
- No burst open: open one with startTag = lastTag = tag and beats = 1.
- tag == lastTag: join the burst; beats unchanged.
- tag == lastTag+1, beats < MAX_BURST, no boundary split: join; beats++ and lastTag = tag.
- Any other tag: close the current burst and open a new one with this pixel, in the same cycle.
- tlast set: the burst containing this pixel closes in the same cycle; the accumulator ends empty.

Idle close: if a burst is open, s_addr_axis_tvalid = 0 and the AR register is free, the burst closes. This guarantees the serializer never waits on a burst that is never issued.

Close action: load araddr from startTag and arlen = beats-1; set arvalid.
- The AR register is free when arvalid = 0, or arvalid && arready in the current cycle.

Flow control:
- s_addr_axis_tready = !fifo_full && (AR register free || the pixel needs no close).
- m_fetch_axis carries the FIFO head. The stream runs independently of AR and may lead AR issue; the serializer stalls on rvalid.

## Timing
- Reset values: s_addr_axis_tready 0 during reset; m_fetch_axis_tvalid 0, tlast 0; arvalid 0; arid, arsize and arburst at their constants; araddr and arlen 0.
- FIFO is emptied and the accumulator is dropped on reset. Reset mid-operation discards the open burst and any pending AR. The serializer and memory must be reset in the same cycle.
- A pixel accepted in cycle N appears on m_fetch_axis_tvalid in N+1 if the FIFO was empty.
- A close in cycle N drives arvalid high in N+1. arvalid, araddr and arlen are held stable until arready.
- Throughput: one pixel per cycle while bursts fit; a close followed by a new open costs no bubble if the AR register is free.
- FIFO full: tready is 0. Simultaneous FIFO read and write when full is allowed; tready stays 0 that cycle because it is computed from the registered full flag.

## Configuration
- FRAMEBUFFER_READ_4K_SPLIT_EN defined: a join is refused when the byte address of lastTag+1 has bits [11:0] == 0. The burst closes there, so no burst crosses a 4 KiB boundary (AXI compliant).
- Not defined: no boundary check; only the MAX_BURST and contiguity rules apply.

## Structure
- Shared package: AXI constants BURST_INCR = 2'b01 and the arsize derivation function; pixel-to-tag shift helper shared with the serializer.
- One sub-module: framebuffer_addr_fifo, a synchronous FIFO with registered full/empty and first-word-fall-through output.

## Test plan
All scenarios use defaults (2 pixels per word). Done when every AR matches the expected list and the fetch stream equals the input order.
- Pixels 0..7 contiguous, tlast on 7, ready held high -> fetch stream 0..7 in order; one AR with araddr 0x0, arlen 3.
- Pixels 0,1,2 then 100 with tlast -> AR 0x0 arlen 1, then AR 0xC8 arlen 0.
- Pixels 0..39, tlast on 39 -> AR 0x0 arlen 15, then AR 0x40 arlen 3.
- Pixels 2044..2051, tlast on 2051 -> with the macro: AR 0xFF8 arlen 1, then AR 0x1000 arlen 1; without the macro: AR 0xFF8 arlen 3.
- arready low for 10 cycles while a second burst needs closing; m_fetch_axis_tready low until 32 entries are buffered -> tready deasserts, no pixel lost or duplicated, AR values stable while waiting.
- Reset asserted mid-burst after pixels 0..5 -> arvalid 0 and m_fetch_axis_tvalid 0 next cycle; a new stream starting at pixel 64 issues an AR at 0x80.
